// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding and default word width.
package serial_rx_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2,
        ST_HOLD = 2'd3
    } rx_state_e;

endpackage

// File: rtl/serial_rx_packer.sv
// Serial receiver that deframes start/data/stop bits into DATA_W-bit words and
// writes each word to a downstream buffer, holding it while the buffer is full.
module serial_rx_packer
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STOP_CHECK = 1
) (
    input  logic              clk_1,
    input  logic              rst,
    input  logic              bit_tick,
    input  logic              rx,
    input  logic              buffer_full,
    input  logic              ovr_clr,
    output logic [DATA_W-1:0] data_1,
    output logic              data_1_en,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    rx_state_e         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] data_q;
    logic              en_q;
    logic              ferr_q;
    logic              ovr_q;
    logic              run_q;
    logic              stop_ok;
    logic              ovr_set;

    assign stop_ok = rx || (STOP_CHECK == 0);
    assign ovr_set = run_q && (state_q == ST_HOLD) && bit_tick && !rx;

    // Reset release is registered once so the FSM cannot act on the first edge after rst rises.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // Receive FSM: start detect, LSB-first shift, stop check, hold while the buffer is full.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            en_q    <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            en_q   <= 1'b0;
            ferr_q <= 1'b0;
            if (run_q) begin
                case (state_q)
                    ST_IDLE: begin
                        if (bit_tick && !rx) begin
                            state_q <= ST_DATA;
                            cnt_q   <= '0;
                        end
                    end
                    ST_DATA: begin
                        if (bit_tick) begin
                            shift_q <= {rx, shift_q[DATA_W-1:1]};
                            cnt_q   <= cnt_q + CNT_W'(1);
                            if (cnt_q == LAST_BIT) begin
                                state_q <= ST_STOP;
                            end
                        end
                    end
                    ST_STOP: begin
                        if (bit_tick) begin
                            if (!stop_ok) begin
                                ferr_q  <= 1'b1;
                                state_q <= ST_IDLE;
                            end else if (!buffer_full) begin
                                data_q  <= shift_q;
                                en_q    <= 1'b1;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_HOLD;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!buffer_full) begin
                            data_q  <= shift_q;
                            en_q    <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // Sticky overrun: a start bit seen while holding sets it; set takes priority over clear.
    always_ff @(posedge clk_1 or negedge rst) begin
        if (!rst) begin
            ovr_q <= 1'b0;
        end else if (ovr_set) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign data_1    = data_q;
    assign data_1_en = en_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
